out_display_driver: RTL and testbench

- Downstream consumer of the output register: samples the 8-bit OUT value and drives a 4-digit multiplexed common-anode seven-segment display.
- Converts binary to BCD with a sequential shift-add-3 (double-dabble) engine, 8 iterations.
- Digits 2..0 show hundreds/tens/ones with leading-zero blanking. Digit 3 is the sign position.
- Exposes the BCD result and a busy/done handshake for the controller.

---
 rtl/out_display_driver.sv | 194 +++++++++++++++++++
 tb/tb_out_display_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/out_display_driver.sv
// Binary-to-BCD display driver for the OUT register. It uses a sequential double-dabble conversion and a 4-digit common-anode seven-segment scan.
// Latency: a result is committed 9 clocks after the load edge, and done pulses in the following cycle. seg and an lag the scan index by 1 clock.
// Backpressure: none. A load while busy goes into a one-deep pending slot (last value wins). Define SIGNED_DISPLAY_EN to treat data_in as two's complement with a minus sign on digit 3.
module out_display_driver #(
    parameter int REFRESH_DIV = 1000,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    state_t      state_q, state_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] scr_q, scr_d;
    logic [2:0]  iter_q, iter_d;
    logic        sgn_q, sgn_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_dat_q, pend_dat_d;
    logic        done_q, done_d;
    logic [11:0] bcd_q, bcd_d;
    logic        disp_sgn_q, disp_sgn_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    // The value fed to the converter is a magnitude. In signed mode a negative input is negated, and 8'h80 maps to 128.
    function automatic logic [7:0] magnitude(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
        return v[7] ? (~v + 8'd1) : v;
`else
        return v;
`endif
    endfunction

    function automatic logic is_neg(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
        return v[7];
`else
        return 1'b0 & v[7];
`endif
    endfunction

    // One double-dabble iteration. Each BCD nibble of 5 or more gets +3, then {bcd,bin} shifts left by one.
    function automatic logic [19:0] dabble(input logic [11:0] b, input logic [7:0] x);
        logic [11:0] a;
        a = b;
        for (int k = 0; k < 3; k++) begin
            if (a[4*k +: 4] >= 4'd5) a[4*k +: 4] = a[4*k +: 4] + 4'd3;
        end
        return {a, x} << 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Conversion FSM next state. A load in COMMIT takes priority over a held pending value, so the last value wins.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        iter_d     = iter_q;
        sgn_d      = sgn_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        disp_sgn_d = disp_sgn_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = magnitude(data_in);
                    sgn_d   = is_neg(data_in);
                    scr_d   = 12'h000;
                    iter_d  = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = dabble(scr_q, bin_q);
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) state_d = COMMIT;
                if (load) begin
                    pend_vld_d = 1'b1;
                    pend_dat_d = data_in;
                end
            end
            COMMIT: begin
                bcd_d      = scr_q;
                disp_sgn_d = sgn_q;
                done_d     = 1'b1;
                pend_vld_d = 1'b0;
                if (load || pend_vld_q) begin
                    bin_d   = magnitude(load ? data_in : pend_dat_q);
                    sgn_d   = is_neg(load ? data_in : pend_dat_q);
                    scr_d   = 12'h000;
                    iter_d  = 3'd0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refresh scan. It runs freely from the FSM, and seg/an are registered from the current index.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d = ~(4'b0001 << idx_q);
        case (idx_q)
            2'd0: seg_d = seg_decode(bcd_q[3:0]);
            2'd1: seg_d = (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) ? SEG_BLANK
                                                                      : seg_decode(bcd_q[7:4]);
            2'd2: seg_d = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_decode(bcd_q[11:8]);
            default: seg_d = disp_sgn_q ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    // State registers. A synchronous active-low reset clears everything and aborts any conversion or pending load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            bin_q      <= 8'h00;
            scr_q      <= 12'h000;
            iter_q     <= 3'd0;
            sgn_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= 8'h00;
            done_q     <= 1'b0;
            bcd_q      <= 12'h000;
            disp_sgn_q <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'hF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            iter_q     <= iter_d;
            sgn_q      <= sgn_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            disp_sgn_q <= disp_sgn_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign seg     = seg_q;
    assign an      = an_q;

endmodule

// File: tb/tb_out_display_driver.sv
// Directed self-checking bench for out_display_driver, built with a fast refresh divider of 4.
// Inputs are driven and outputs are sampled 1ns after each rising edge.
// Without flow control, tests cover reset, conversion latency, blanking, the scan, back-to-back loads, reset abort and the signed build.
module tb_out_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        load;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_pass   = 0;

    out_display_driver #(.REFRESH_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .busy(busy), .done(done), .bcd_out(bcd_out), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [7:0] v);
        load = 1'b1;
        data_in = v;
        tick();
        load = 1'b0;
    endtask

    // Waits for the done pulse, counting busy cycles from the load edge onwards.
    task automatic wait_done(input string tag, output int nbusy);
        bit seen = 0;
        nbusy = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) nbusy++;
                tick();
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Waits for the given anode pattern and then compares seg.
    task automatic check_digit(input string tag, input logic [3:0] an_val, input logic [6:0] exp_seg);
        bit seen = 0;
        for (int i = 0; i < 24 && !seen; i++) begin
            if (an == an_val) seen = 1;
            else tick();
        end
        if (seen) check(tag, 32'(seg), 32'(exp_seg));
        else check({tag, "_timeout"}, 32'(an), 32'(an_val));
    endtask

    initial begin
        int nb, ndone, nbusy_run, last_tr;
        logic [3:0] prev_an;
        logic [11:0] res [2];

        reset = 1'b0; load = 1'b0; data_in = 8'h00;
        tick(); tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'h000);
        reset = 1'b1;
        tick();
        check("rel_an", 32'(an), 32'hE);
        check("rel_seg0", 32'(seg), 32'h40);

`ifndef SIGNED_DISPLAY_EN
        // 255 is the full unsigned range.
        load_val(8'd255);
        wait_done("full", nb);
        check("full_busy_cycles", 32'(nb), 32'd9);
        check("full_bcd", 32'(bcd_out), 32'h255);
        check("full_busy_at_done", 32'(busy), 32'd0);
        tick();
        check("full_done_pulse", 32'(done), 32'd0);
`endif

        // Digit blanking and scan order for the value 7.
        load_val(8'd7);
        wait_done("seven", nb);
        check("seven_bcd", 32'(bcd_out), 32'h007);
        tick(); tick();
        prev_an = an;
        last_tr = -1;
        for (int i = 0; i < 36; i++) begin
            check("seven_seg", 32'(seg), (an == 4'b1110) ? 32'h78 : 32'h7F);
            if (an != prev_an) begin
                check("scan_order", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
                if (last_tr >= 0) check("scan_hold", 32'(i - last_tr), 32'd4);
                last_tr = i;
                prev_an = an;
            end
            tick();
        end

        // For 105, the tens zero shows because hundreds is non-zero.
        load_val(8'd105);
        wait_done("d105", nb);
        check("d105_bcd", 32'(bcd_out), 32'h105);
        tick(); tick();
        check_digit("d105_tens", 4'b1101, 7'h40);
        check_digit("d105_hund", 4'b1011, 7'h79);
        check_digit("d105_ones", 4'b1110, 7'h12);
        check_digit("d105_sign", 4'b0111, 7'h7F);

        // Back-to-back loads. 42 is overwritten by 43 while busy.
        load_val(8'd100);
        nbusy_run = 0; ndone = 0;
        res[0] = '0; res[1] = '0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nbusy_run++;
            if (done) begin
                if (ndone < 2) res[ndone] = bcd_out;
                ndone++;
            end
            load = (i == 2 || i == 5);
            data_in = (i == 2) ? 8'd42 : 8'd43;
            tick();
        end
        load = 1'b0;
        check("b2b_busy_cycles", 32'(nbusy_run), 32'd18);
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_first", 32'(res[0]), 32'h100);
        check("b2b_second", 32'(res[1]), 32'h043);

        // A reset during conversion of 200 with a pending value.
        load_val(8'd200);
        load_val(8'd9);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        check("abort_an", 32'(an), 32'hF);
        check("abort_seg", 32'(seg), 32'h7F);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'h000);
        reset = 1'b1;
        ndone = 0; nb = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            if (busy) nb++;
            tick();
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_no_busy", 32'(nb), 32'd0);
        check_digit("abort_digit0", 4'b1110, 7'h40);

`ifdef SIGNED_DISPLAY_EN
        load_val(8'h80);
        wait_done("s80", nb);
        check("s80_bcd", 32'(bcd_out), 32'h128);
        tick(); tick();
        check_digit("s80_sign", 4'b0111, 7'h3F);
        load_val(8'h7F);
        wait_done("s7f", nb);
        check("s7f_bcd", 32'(bcd_out), 32'h127);
        tick(); tick();
        check_digit("s7f_sign", 4'b0111, 7'h7F);
        load_val(8'hFF);
        wait_done("sff", nb);
        check("sff_bcd", 32'(bcd_out), 32'h001);
        tick(); tick();
        check_digit("sff_sign", 4'b0111, 7'h3F);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
